// File: rtl/johnson_seq_monitor.sv
// Monitors a 4-bit Johnson counter: locks after LOCK_N correct successors, latches a sticky fault on any break.
// Optional completed-cycle counter and cycle_cnt port are enabled by defining JSEQ_CYCLE_CNT_EN.
module johnson_seq_monitor #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q_in,
    input  logic       in_valid,
    input  logic       clr,
    output logic [2:0] phase,
    output logic [7:0] phase_oh,
    output logic       locked,
    output logic       seq_err,
    output logic       wrap
`ifdef JSEQ_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_UNLOCK = 2'd0,
        ST_LOCK   = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_N);

    state_t     state_q, state_d;
    logic [2:0] phase_q, phase_d;
    logic [7:0] phase_oh_q, phase_oh_d;
    logic [3:0] match_q, match_d;
    logic       wrap_q, wrap_d;

    logic       code_legal;
    logic [2:0] code_phase;
    logic       is_succ;
    logic [3:0] match_inc;

    always_comb begin
        code_legal = 1'b1;
        code_phase = 3'd0;
        case (q_in)
            4'b0000: code_phase = 3'd0;
            4'b1000: code_phase = 3'd1;
            4'b1100: code_phase = 3'd2;
            4'b1110: code_phase = 3'd3;
            4'b1111: code_phase = 3'd4;
            4'b0111: code_phase = 3'd5;
            4'b0011: code_phase = 3'd6;
            4'b0001: code_phase = 3'd7;
            default: code_legal = 1'b0;
        endcase
    end

    // A non-zero phase_oh_q means a legal sample is held, so a successor relation is defined.
    assign is_succ   = code_legal && (|phase_oh_q) && (code_phase == phase_q + 3'd1);
    assign match_inc = match_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        phase_oh_d = phase_oh_q;
        match_d    = match_q;
        wrap_d     = 1'b0;
        if (clr) begin
            state_d    = ST_UNLOCK;
            phase_oh_d = 8'd0;
            match_d    = 4'd0;
        end else if (in_valid) begin
            case (state_q)
                ST_UNLOCK: begin
                    if (code_legal) begin
                        phase_d    = code_phase;
                        phase_oh_d = 8'b1 << code_phase;
                        if (is_succ) begin
                            match_d = match_inc;
                            if (match_inc == LOCK_TARGET) begin
                                state_d = ST_LOCK;
                            end
                        end else begin
                            match_d = 4'd0;
                        end
                    end else begin
                        phase_oh_d = 8'd0;
                        match_d    = 4'd0;
                    end
                end
                ST_LOCK: begin
                    if (is_succ) begin
                        phase_d    = code_phase;
                        phase_oh_d = 8'b1 << code_phase;
                        wrap_d     = (phase_q == 3'd7);
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_UNLOCK;
            phase_q    <= 3'd0;
            phase_oh_q <= 8'd0;
            match_q    <= 4'd0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            phase_oh_q <= phase_oh_d;
            match_q    <= match_d;
            wrap_q     <= wrap_d;
        end
    end

`ifdef JSEQ_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts locked 7->0 transitions; rolls over silently.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (wrap_d) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`else
    // CNT_W only sizes the optional counter; an empty block keeps it referenced.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

    assign phase    = phase_q;
    assign phase_oh = phase_oh_q;
    assign locked   = (state_q == ST_LOCK);
    assign seq_err  = (state_q == ST_FAULT);
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Self-checking bench for johnson_seq_monitor: behavioural model, per-cycle compare, directed and random stimulus.
// Define JSEQ_CYCLE_CNT_EN to also check cycle_cnt.
module tb_johnson_seq_monitor;

    localparam int CNT_W  = 2;
    localparam int LOCK_N = 2;

    localparam logic [3:0] CODES [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                                         4'b1111, 4'b0111, 4'b0011, 4'b0001};

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       q_in = 4'd0;
    logic             in_valid = 1'b0;
    logic             clr = 1'b0;
    logic [2:0]       phase;
    logic [7:0]       phase_oh;
    logic             locked;
    logic             seq_err;
    logic             wrap;
`ifdef JSEQ_CYCLE_CNT_EN
    logic [CNT_W-1:0] cycle_cnt;
`endif

    int total = 0;
    int bad = 0;
    int wrap_seen = 0;
    bit cmp_en = 1'b0;

    johnson_seq_monitor #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
        .clk      (clk),
        .rst      (rst),
        .q_in     (q_in),
        .in_valid (in_valid),
        .clr      (clr),
        .phase    (phase),
        .phase_oh (phase_oh),
        .locked   (locked),
        .seq_err  (seq_err),
        .wrap     (wrap)
`ifdef JSEQ_CYCLE_CNT_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model: mode 0 = hunting, 1 = locked, 2 = faulted.
    typedef struct packed {
        logic [1:0]       mode;
        logic [2:0]       ph;
        logic             held;
        logic [3:0]       run;
        logic [CNT_W-1:0] cnt;
        logic             wrp;
    } model_t;

    model_t m;

    function automatic model_t reset_model();
        model_t r;
        r = '0;
        return r;
    endfunction

    function automatic model_t step(model_t cur, logic [3:0] q, logic v, logic c);
        model_t n;
        int idx;
        int nxt;
        n = cur;
        n.wrp = 1'b0;
        if (c) begin
            n.mode = 2'd0;
            n.held = 1'b0;
            n.run  = 4'd0;
            n.cnt  = '0;
            return n;
        end
        if (!v) return n;
        idx = -1;
        for (int i = 0; i < 8; i++) if (CODES[i] == q) idx = i;
        nxt = (int'(cur.ph) + 1) % 8;
        if (cur.mode == 2'd0) begin
            if (idx < 0) begin
                n.held = 1'b0;
                n.run  = 4'd0;
            end else begin
                if (cur.held && idx == nxt) begin
                    n.run = 4'(int'(cur.run) + 1);
                    if (int'(cur.run) + 1 == LOCK_N) n.mode = 2'd1;
                end else begin
                    n.run = 4'd0;
                end
                n.ph   = 3'(idx);
                n.held = 1'b1;
            end
        end else if (cur.mode == 2'd1) begin
            if (idx >= 0 && idx == nxt) begin
                n.ph = 3'(idx);
                if (idx == 0) begin
                    n.wrp = 1'b1;
                    n.cnt = CNT_W'((int'(cur.cnt) + 1) % (1 << CNT_W));
                end
            end else begin
                n.mode = 2'd2;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= reset_model();
        else      m <= step(m, q_in, in_valid, clr);
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp phase", int'(phase), int'(m.ph));
            chk("cmp phase_oh", int'(phase_oh), m.held ? (1 << int'(m.ph)) : 0);
            chk("cmp locked", int'(locked), (m.mode == 2'd1) ? 1 : 0);
            chk("cmp seq_err", int'(seq_err), (m.mode == 2'd2) ? 1 : 0);
            chk("cmp wrap", int'(wrap), int'(m.wrp));
`ifdef JSEQ_CYCLE_CNT_EN
            chk("cmp cycle_cnt", int'(cycle_cnt), int'(m.cnt));
`endif
            if (wrap) wrap_seen++;
        end
    end

    task automatic tick(input logic [3:0] q, input logic v, input logic c);
        q_in = q;
        in_valid = v;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " phase"}, int'(phase), 0);
        chk({tag, " phase_oh"}, int'(phase_oh), 0);
        chk({tag, " locked"}, int'(locked), 0);
        chk({tag, " seq_err"}, int'(seq_err), 0);
        chk({tag, " wrap"}, int'(wrap), 0);
`ifdef JSEQ_CYCLE_CNT_EN
        chk({tag, " cycle_cnt"}, int'(cycle_cnt), 0);
`endif
    endtask

    initial begin
        int p;
        int w0;
        int exp_cnt [5] = '{1, 2, 3, 0, 1};
        int wr;

        // Reset and release synchronously
        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check_reset_values("reset");
        rst = 1'b1;

        $display("scenario: lock from 1000");
        tick(CODES[1], 1'b1, 1'b0);
        chk("first phase", int'(phase), 1);
        chk("first phase_oh", int'(phase_oh), 8'h02);
        chk("first locked", int'(locked), 0);
        tick(CODES[2], 1'b1, 1'b0);
        chk("second locked", int'(locked), 0);
        tick(CODES[3], 1'b1, 1'b0);
        chk("lock locked", int'(locked), 1);
        chk("lock phase", int'(phase), 3);
        chk("lock seq_err", int'(seq_err), 0);

        $display("scenario: five locked cycles");
        p = 3;
        w0 = wrap_seen;
        wr = 0;
        for (int n = 0; n < 40; n++) begin
            p = (p + 1) % 8;
            tick(CODES[p], 1'b1, 1'b0);
            if (p == 0) begin
                chk("wrap pulse", int'(wrap), 1);
`ifdef JSEQ_CYCLE_CNT_EN
                chk("cycle_cnt wrap seq", int'(cycle_cnt), exp_cnt[wr]);
`endif
                wr++;
            end else begin
                chk("wrap low", int'(wrap), 0);
            end
        end
        chk("wrap count", wrap_seen - w0, 5);
        chk("still locked", int'(locked), 1);

        $display("scenario: illegal inject 1010");
        tick(4'b1010, 1'b1, 1'b0);
        chk("inject seq_err", int'(seq_err), 1);
        chk("inject locked", int'(locked), 0);
        chk("inject phase", int'(phase), 3);
        tick(CODES[4], 1'b1, 1'b0);
        tick(CODES[5], 1'b1, 1'b0);
        chk("fault sticky", int'(seq_err), 1);
        chk("fault phase hold", int'(phase), 3);
        tick(CODES[6], 1'b1, 1'b1);
        chk("clr seq_err", int'(seq_err), 0);
        chk("clr locked", int'(locked), 0);
        chk("clr phase_oh", int'(phase_oh), 0);
`ifdef JSEQ_CYCLE_CNT_EN
        chk("clr cycle_cnt", int'(cycle_cnt), 0);
`endif

        $display("scenario: skip from phase 2");
        tick(CODES[0], 1'b1, 1'b0);
        tick(CODES[1], 1'b1, 1'b0);
        tick(CODES[2], 1'b1, 1'b0);
        chk("relock locked", int'(locked), 1);
        chk("relock phase", int'(phase), 2);
        tick(CODES[4], 1'b1, 1'b0);
        chk("skip seq_err", int'(seq_err), 1);
        chk("skip phase", int'(phase), 2);
        tick(4'd0, 1'b0, 1'b1);

        $display("scenario: repeat 1100");
        tick(CODES[0], 1'b1, 1'b0);
        tick(CODES[1], 1'b1, 1'b0);
        tick(CODES[2], 1'b1, 1'b0);
        tick(CODES[2], 1'b1, 1'b0);
        chk("repeat seq_err", int'(seq_err), 1);
        tick(4'd0, 1'b0, 1'b1);

        $display("scenario: in_valid toggling");
        tick(CODES[0], 1'b1, 1'b0);
        tick(CODES[1], 1'b1, 1'b0);
        tick(CODES[2], 1'b1, 1'b0);
        tick(CODES[3], 1'b1, 1'b0);
        chk("toggle phase a", int'(phase), 3);
        tick(4'b1010, 1'b0, 1'b0);
        chk("toggle phase b", int'(phase), 3);
        tick(CODES[4], 1'b1, 1'b0);
        chk("toggle phase c", int'(phase), 4);
        tick(4'b0101, 1'b0, 1'b0);
        chk("toggle phase d", int'(phase), 4);
        chk("toggle locked", int'(locked), 1);

        $display("scenario: async reset in LOCK");
        #3;
        rst = 1'b0;
        #1;
        check_reset_values("async lock");
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("scenario: async reset in FAULT");
        tick(CODES[1], 1'b1, 1'b0);
        tick(CODES[2], 1'b1, 1'b0);
        tick(CODES[3], 1'b1, 1'b0);
        tick(4'b1010, 1'b1, 1'b0);
        chk("pre reset seq_err", int'(seq_err), 1);
        #3;
        rst = 1'b0;
        #1;
        check_reset_values("async fault");
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("scenario: random run");
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [3:0] q;
            r = int'($urandom_range(0, 99));
            if (r < 65)      q = CODES[(int'(m.ph) + 1) % 8];
            else if (r < 80) q = CODES[$urandom_range(0, 7)];
            else             q = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                tick(q, 1'b1, 1'b0);
                rst = 1'b1;
            end else begin
                tick(q, ($urandom_range(0, 4) != 0), ($urandom_range(0, 59) == 0));
            end
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/johnson_seq_monitor.md
JOHNSON_SEQ_MONITOR -- requirements
Module: johnson_seq_monitor

Interface
REQ-001 Parameter CNT_W, default 8, width of the completed-cycle counter.
REQ-002 Parameter LOCK_N, default 2, number of consecutive correct successor samples needed to lock (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; asserts immediately, releases synchronously to clk.
REQ-005 q_in  input  4  state of the upstream 4-bit Johnson counter.
REQ-006 in_valid  input  1  q_in is sampled only on cycles with in_valid=1.
REQ-007 clr  input  1  synchronous clear of fault, lock and counter.
REQ-008 phase  output  3  registered phase index of the last legal sample.
REQ-009 phase_oh  output  8  registered one-hot of phase; all zero when no legal sample is held.
REQ-010 locked  output  1  high in state LOCK.
REQ-011 seq_err  output  1  sticky fault flag, high in state FAULT.
REQ-012 wrap  output  1  one-cycle pulse on a locked 7->0 transition.
REQ-013 cycle_cnt  output  CNT_W  count of completed sequences (present only per REQ-031).

Function
REQ-014 Legal codes and phase map: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7; the other 8 codes are illegal.
REQ-015 Successor of phase p is (p+1) mod 8; phase 7 wraps to phase 0.
REQ-016 Outputs are registered: a sample taken at edge N is reflected on the outputs after edge N; latency is 1 cycle.
REQ-017 in_valid=0: no state, phase, counter or flag changes; wrap=0.
REQ-018 The FSM has three states: UNLOCK, LOCK and FAULT.
REQ-019 UNLOCK, legal sample: phase is loaded. A sample that is the successor of the held phase increments the match count; any other legal sample restarts the count at 0.
REQ-020 UNLOCK, illegal sample: phase_oh=0, the match count clears, and the FSM stays in UNLOCK with no fault.
REQ-021 UNLOCK -> LOCK on the sample that brings the match count to LOCK_N.
REQ-022 LOCK, successor sample: phase advances. On 7->0, wrap pulses and cycle_cnt increments.
REQ-023 LOCK, illegal or non-successor sample (repeat values included): FAULT; seq_err=1, locked=0, and phase holds its last legal value.
REQ-024 FAULT: all samples are ignored and the FSM stays in FAULT until clr.
REQ-025 clr=1, any state: next state UNLOCK, seq_err=0, match count=0, cycle_cnt=0, phase_oh=0, wrap=0. clr overrides a simultaneous sample.
REQ-026 cycle_cnt wraps from 2^CNT_W-1 to 0 with no flag.
REQ-027 wrap is never high in UNLOCK or FAULT, including on the locking sample.

Reset
REQ-028 While rst=0, the block is held in UNLOCK with: phase=0, phase_oh=0, locked=0, seq_err=0, wrap=0, cycle_cnt=0, match count=0.
REQ-029 Reset asserted mid-operation, including in FAULT, takes effect immediately regardless of clk.
REQ-030 The first sample is accepted on the first rising edge after rst release.

Configuration
REQ-031 Macro JSEQ_CYCLE_CNT_EN.
- Defined: cycle_cnt port and counter are present and behave per REQ-022, REQ-025 and REQ-026.
- Undefined: the port and counter are absent; wrap still behaves per REQ-022.

Verification
REQ-032 Reset release, then one continuous legal sequence from 1000 with in_valid=1, LOCK_N=2 -> locked=1 after the third sample (1110), phase=3, seq_err=0.
REQ-033 Locked sequence run for 3 full cycles -> wrap pulses 3 times, each one cycle long following the 0001->0000 sample; cycle_cnt=3 (macro defined).
REQ-034 Locked, inject q_in=1010 -> next cycle seq_err=1, locked=0, phase holds; further legal samples leave the flags unchanged; clr=1 for one cycle -> seq_err=0, UNLOCK, cycle_cnt=0.
REQ-035 Locked at phase 2 (1100), skip to 1111 -> FAULT. Separately, repeat 1100 twice -> FAULT.
REQ-036 Legal run with in_valid toggled 1,0,1,0 -> phase advances only on in_valid=1 cycles and the FSM stays in LOCK. Then assert rst=0 between edges -> all outputs reach reset values before the next edge.
REQ-037 CNT_W=2 with macro defined, 5 locked cycles -> cycle_cnt reads 1,2,3,0,1. Macro undefined -> build has no cycle_cnt port and wrap behaviour is unchanged.
